// File: rtl/alpha_pe_array_pkg.sv
// Shared constants and helpers for the alpha processing-element array
// of the SCAN polar decoder.
package alpha_pe_array_pkg;

    localparam int Q_DEF   = 6;
    localparam int P_DEF   = 128;
    localparam int N_DEF   = 1024;
    localparam int LAYER_W = 5;

    localparam logic MODE_F = 1'b0;
    localparam logic MODE_G = 1'b1;

    localparam int LLR_MAX = (1 << (Q_DEF - 1)) - 1;

    // Symmetric clamp: the most negative code is never produced
    function automatic logic signed [Q_DEF-1:0] saturate(input logic signed [Q_DEF:0] x);
        if (x > LLR_MAX) begin
            return Q_DEF'(LLR_MAX);
        end
        if (x < -LLR_MAX) begin
            return Q_DEF'(-LLR_MAX);
        end
        return x[Q_DEF-1:0];
    endfunction

endpackage

// File: rtl/alpha_pe_lane.sv
// Single-lane min-sum f / g unit: raw result registered in stage 1,
// saturated and masked result registered in stage 2.
module alpha_pe_lane
    import alpha_pe_array_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en_s1,
    input  logic             i_en_s2,
    input  logic             i_mode,
    input  logic             i_beta,
    input  logic             i_keep,
    input  logic [Q_DEF-1:0] i_a,
    input  logic [Q_DEF-1:0] i_b,
    output logic [Q_DEF-1:0] o_res
);

    localparam int LW = Q_DEF;

    logic signed [LW:0] w_a_ext;
    logic signed [LW:0] w_b_ext;
    logic signed [LW:0] w_abs_a;
    logic signed [LW:0] w_abs_b;
    logic signed [LW:0] w_min;
    logic signed [LW:0] w_f;
    logic signed [LW:0] w_g;
    logic signed [LW:0] w_raw;

    logic signed [LW:0] r_raw;
    logic               r_keep;
    logic [LW-1:0]      r_res;

    // One extra bit so that |-2^(Q-1)| and b +/- a are exact
    assign w_a_ext = {i_a[LW-1], i_a};
    assign w_b_ext = {i_b[LW-1], i_b};
    assign w_abs_a = w_a_ext[LW] ? -w_a_ext : w_a_ext;
    assign w_abs_b = w_b_ext[LW] ? -w_b_ext : w_b_ext;
    assign w_min   = (w_abs_a < w_abs_b) ? w_abs_a : w_abs_b;
    assign w_f     = (i_a[LW-1] ^ i_b[LW-1]) ? -w_min : w_min;
    assign w_g     = i_beta ? (w_b_ext - w_a_ext) : (w_b_ext + w_a_ext);
    assign w_raw   = (i_mode == MODE_G) ? w_g : w_f;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_raw  <= '0;
            r_keep <= 1'b0;
            r_res  <= '0;
        end else begin
            if (i_en_s1) begin
                r_raw  <= w_raw;
                r_keep <= i_keep;
            end
            if (i_en_s2) begin
                r_res <= r_keep ? saturate(r_raw) : '0;
            end
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/alpha_pe_array.sv
// P-lane LLR processing array between the alpha RAM read and write ports.
// Selects operands, runs P lane units and pipelines the write control fields.
module alpha_pe_array
    import alpha_pe_array_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int P = P_DEF,
    parameter int N = N_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic               mode,
    input  logic [LAYER_W-1:0] layer_in,
    input  logic [LAYER_W-1:0] cnt_in,
    input  logic [P*Q-1:0]     a_left,
    input  logic [P*Q-1:0]     a_right,
    input  logic [P-1:0]       beta_in,
    output logic [P*Q-1:0]     a_out,
    output logic               out_valid,
    output logic [LAYER_W-1:0] layer_out,
    output logic [LAYER_W-1:0] cnt_out
);

    localparam int               MAX_LAYER   = $clog2(N);
    localparam logic [LAYER_W-1:0] MAX_LAYER_L = LAYER_W'(MAX_LAYER);
    localparam int               SPLIT_LAYER = 5;

    logic               w_cmd_ok;
    logic               w_en_s1;
    logic               w_en_s2;
    logic [P*Q-1:0]     w_right;
    logic [P-1:0]       w_keep;

    logic               r_v1;
    logic               r_v2;
    logic [LAYER_W-1:0] r_layer1;
    logic [LAYER_W-1:0] r_cnt1;
    logic [LAYER_W-1:0] r_layer2;
    logic [LAYER_W-1:0] r_cnt2;

    assign w_cmd_ok = in_valid && (layer_in != '0) && (layer_in <= MAX_LAYER_L);
    assign w_en_s1  = w_cmd_ok && !clr;
    assign w_en_s2  = r_v1 && !clr;

    // Small layers keep both halves in a_left: lane i pairs with lane i+n
    always_comb begin
        w_right = a_right;
        if (layer_in <= LAYER_W'(SPLIT_LAYER)) begin
            w_right = '0;
            for (int i = 0; i < P; i++) begin
                for (int s = 1; s <= SPLIT_LAYER; s++) begin
                    if ((layer_in == LAYER_W'(s)) && ((i + (1 << (s - 1))) < P)) begin
                        w_right[i*Q +: Q] = a_left[(i + (1 << (s - 1)))*Q +: Q];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_layer1 <= '0;
            r_cnt1   <= '0;
            r_layer2 <= '0;
            r_cnt2   <= '0;
        end else begin
            r_v1 <= w_en_s1;
            r_v2 <= w_en_s2;
            if (w_en_s1) begin
                r_layer1 <= layer_in - LAYER_W'(1);
                r_cnt1   <= cnt_in;
            end
            if (w_en_s2) begin
                r_layer2 <= r_layer1;
                r_cnt2   <= r_cnt1;
            end
        end
    end

    assign out_valid = r_v2;
    assign layer_out = r_layer2;
    assign cnt_out   = r_cnt2;

    for (genvar g = 0; g < P; g++) begin : g_lane
        // Lane g is active when g < n = 2^(layer_in-1)
        assign w_keep[g] = (32'd1 << (layer_in - LAYER_W'(1))) > 32'(g);

        alpha_pe_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_en_s1 (w_en_s1),
            .i_en_s2 (w_en_s2),
            .i_mode  (mode),
            .i_beta  (beta_in[g]),
            .i_keep  (w_keep[g]),
            .i_a     (a_left[g*Q +: Q]),
            .i_b     (w_right[g*Q +: Q]),
            .o_res   (a_out[g*Q +: Q])
        );
    end

endmodule

// File: tb/tb_alpha_pe_array.sv
// Self-checking bench for alpha_pe_array: directed scenarios plus a
// randomized stream checked against a lane-by-lane arithmetic model.
module tb_alpha_pe_array;

    localparam int Q   = 6;
    localparam int P   = 128;
    localparam int N   = 1024;
    localparam int V   = P * Q;
    localparam int LIM = (1 << (Q - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         mode;
    logic [4:0]   layer_in;
    logic [4:0]   cnt_in;
    logic [V-1:0] a_left;
    logic [V-1:0] a_right;
    logic [P-1:0] beta_in;
    logic [V-1:0] a_out;
    logic         out_valid;
    logic [4:0]   layer_out;
    logic [4:0]   cnt_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alpha_pe_array #(.Q(Q), .P(P), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .mode      (mode),
        .layer_in  (layer_in),
        .cnt_in    (cnt_in),
        .a_left    (a_left),
        .a_right   (a_right),
        .beta_in   (beta_in),
        .a_out     (a_out),
        .out_valid (out_valid),
        .layer_out (layer_out),
        .cnt_out   (cnt_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [V-1:0] randVec();
        logic [V-1:0] v;
        for (int i = 0; i < V / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [P-1:0] randBeta();
        logic [P-1:0] v;
        for (int i = 0; i < P / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int laneVal(input logic [V-1:0] v, input int idx);
        logic signed [Q-1:0] t;
        t = v[idx*Q +: Q];
        return int'(t);
    endfunction

    function automatic logic [V-1:0] setLane(input logic [V-1:0] v, input int idx, input int val);
        logic [31:0] t;
        t = val;
        v[idx*Q +: Q] = t[Q-1:0];
        return v;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: n = 2^(layer-1), min(P,n) active lanes, symmetric clamp
    function automatic logic [V-1:0] model(input logic m, input int layer, input logic [V-1:0] l,
                                           input logic [V-1:0] r, input logic [P-1:0] b);
        logic [V-1:0] v;
        int n, act, x, y, res, mag;
        v   = '0;
        n   = 1 << (layer - 1);
        act = (n < P) ? n : P;
        for (int i = 0; i < act; i++) begin
            x = laneVal(l, i);
            y = (layer <= 5) ? laneVal(l, i + n) : laneVal(r, i);
            if (m == 1'b0) begin
                mag = (iabs(x) < iabs(y)) ? iabs(x) : iabs(y);
                res = ((x < 0) != (y < 0)) ? -mag : mag;
            end else begin
                res = b[i] ? (y - x) : (y + x);
            end
            if (res > LIM) res = LIM;
            if (res < -LIM) res = -LIM;
            v = setLane(v, i, res);
        end
        return v;
    endfunction

    task automatic applyStimulus(input logic v, input logic m, input int layer, input int cnt,
                                 input logic [V-1:0] l, input logic [V-1:0] r, input logic [P-1:0] b);
        in_valid = v;
        mode     = m;
        layer_in = 5'(layer);
        cnt_in   = 5'(cnt);
        a_left   = l;
        a_right  = r;
        beta_in  = b;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr = 1'b0;
        applyStimulus(1'b1, 1'($urandom()), 9, 1, randVec(), randVec(), randBeta());
        for (int c = 0; c < 5; c++) begin
            if (c == 3) begin
                rst      = 1'b1;
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cycle %0d: got %b, expected 0", c, out_valid);
            end
            checks++;
            if (a_out !== '0) begin
                errors++;
                $display("[TB] FAIL reset_data cycle %0d: got %h, expected 0", c, a_out);
            end
        end
    endtask

    task automatic test_f_saturation();
        int av[3]  = '{-32, -32, 5};
        int bv[3]  = '{20, -32, -7};
        int ev[3]  = '{-20, 31, -5};
        logic [V-1:0] l, r, expVec;
        logic [P-1:0] b;
        for (int k = 0; k < 3; k++) begin
            l = setLane(randVec(), 0, av[k]);
            r = setLane(randVec(), 0, bv[k]);
            b = randBeta();
            expVec = model(1'b0, 9, l, r, b);
            applyStimulus(1'b1, 1'b0, 9, k + 4, l, r, b);
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL f_early_valid case %0d: got %b, expected 0", k, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL f_valid case %0d: got %b, expected 1", k, out_valid);
            end
            checks++;
            if (laneVal(a_out, 0) != ev[k]) begin
                errors++;
                $display("[TB] FAIL f_lane0 case %0d: got %0d, expected %0d", k, laneVal(a_out, 0), ev[k]);
            end
            checks++;
            if (a_out !== expVec) begin
                errors++;
                $display("[TB] FAIL f_vector case %0d: got %h, expected %h", k, a_out, expVec);
            end
            checks++;
            if (layer_out !== 5'd8 || cnt_out !== 5'(k + 4)) begin
                errors++;
                $display("[TB] FAIL f_ctrl case %0d: got layer %0d cnt %0d, expected 8 %0d",
                         k, layer_out, cnt_out, k + 4);
            end
        end
    endtask

    task automatic test_g_saturation();
        int av[3] = '{25, 25, -31};
        int bv[3] = '{20, 20, -31};
        int ev[3] = '{31, -5, -31};
        logic bt[3] = '{1'b0, 1'b1, 1'b0};
        logic [V-1:0] l, r, expVec;
        logic [P-1:0] b;
        for (int k = 0; k < 3; k++) begin
            l = '0;
            r = '0;
            expVec = '0;
            for (int i = 0; i < P; i++) begin
                l = setLane(l, i, av[k]);
                r = setLane(r, i, bv[k]);
                expVec = setLane(expVec, i, ev[k]);
            end
            b = {P{bt[k]}};
            applyStimulus(1'b1, 1'b1, 8, 9, l, r, b);
            tick();
            in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || a_out !== expVec) begin
                errors++;
                $display("[TB] FAIL g_sat case %0d: got valid %b data %h, expected 1 %h",
                         k, out_valid, a_out, expVec);
            end
            checks++;
            if (layer_out !== 5'd7) begin
                errors++;
                $display("[TB] FAIL g_layer case %0d: got %0d, expected 7", k, layer_out);
            end
        end
    endtask

    task automatic test_split();
        int lv[8] = '{1, 2, 3, 4, -5, 6, -7, 8};
        int ev[4] = '{-1, 2, -3, 4};
        logic [V-1:0] l, expVec;
        l = randVec();
        for (int i = 0; i < 8; i++) l = setLane(l, i, lv[i]);
        expVec = '0;
        for (int i = 0; i < 4; i++) expVec = setLane(expVec, i, ev[i]);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b0, 3, 2, l, randVec(), randBeta());
            tick();
            in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || a_out !== expVec) begin
                errors++;
                $display("[TB] FAIL split pass %0d: got valid %b data %h, expected 1 %h",
                         k, out_valid, a_out, expVec);
            end
            checks++;
            if (a_out !== model(1'b0, 3, l, a_right, beta_in)) begin
                errors++;
                $display("[TB] FAIL split_model pass %0d: got %h", k, a_out);
            end
        end
    endtask

    task automatic test_back_to_back(input logic useClr);
        logic [V-1:0] expVec[5];
        logic         expValid[5];
        int           lay[5];
        logic [V-1:0] l, r;
        logic [P-1:0] b;
        logic         m;
        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                l = randVec();
                r = randVec();
                b = randBeta();
                m = 1'($urandom());
                lay[t] = $urandom_range(1, 10);
                expVec[t] = model(m, lay[t], l, r, b);
                expValid[t] = !(useClr && (t == 1 || t == 2));
                applyStimulus(1'b1, m, lay[t], t, l, r, b);
                clr = useClr && (t == 2);
            end else begin
                if (t == 4) expValid[4] = 1'b0;
                in_valid = 1'b0;
                clr = 1'b0;
            end
            tick();
            if (t >= 1) begin
                checks++;
                if (out_valid !== expValid[t-1]) begin
                    errors++;
                    $display("[TB] FAIL b2b_valid clr=%0b slot %0d: got %b, expected %b",
                             useClr, t - 1, out_valid, expValid[t-1]);
                end
                if (expValid[t-1]) begin
                    checks++;
                    if (a_out !== expVec[t-1] || cnt_out !== 5'(t - 1) || layer_out !== 5'(lay[t-1] - 1)) begin
                        errors++;
                        $display("[TB] FAIL b2b_data clr=%0b slot %0d: got cnt %0d layer %0d data %h, expected %0d %0d %h",
                                 useClr, t - 1, cnt_out, layer_out, a_out, t - 1, lay[t-1] - 1, expVec[t-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid_layer();
        logic [V-1:0] l, r, expVec;
        int lays[3] = '{0, 11, 7};
        l = '0;
        r = '0;
        expVec = '0;
        for (int i = 0; i < P; i++) begin
            l = setLane(l, i, 3);
            r = setLane(r, i, 4);
            if (i < 64) expVec = setLane(expVec, i, 1);
        end
        for (int t = 0; t < 5; t++) begin
            if (t < 3) applyStimulus(1'b1, 1'b1, lays[t], 12, l, r, {P{1'b1}});
            else in_valid = 1'b0;
            tick();
            if (t >= 1) begin
                checks++;
                if (out_valid !== (t == 3)) begin
                    errors++;
                    $display("[TB] FAIL invalid_layer_valid slot %0d: got %b, expected %b", t - 1, out_valid, (t == 3));
                end
            end
            if (t == 3) begin
                checks++;
                if (a_out !== expVec || layer_out !== 5'd6) begin
                    errors++;
                    $display("[TB] FAIL layer7_g: got layer %0d data %h, expected 6 %h", layer_out, a_out, expVec);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        localparam int T = 40;
        logic [V-1:0] expVec[T+2];
        logic         okIn[T+2];
        logic         clrIn[T+2];
        int           lay[T+2];
        int           cnt[T+2];
        logic         expValid;
        logic [V-1:0] l, r;
        logic [P-1:0] b;
        logic         m, v;
        for (int t = 0; t < T + 2; t++) begin
            if (t < T) begin
                l = randVec();
                r = randVec();
                b = randBeta();
                m = 1'($urandom());
                v = ($urandom_range(0, 3) != 0);
                lay[t] = $urandom_range(0, 12);
                cnt[t] = $urandom_range(0, 31);
                okIn[t] = v && lay[t] >= 1 && lay[t] <= 10;
                clrIn[t] = ($urandom_range(0, 9) == 0);
                expVec[t] = okIn[t] ? model(m, lay[t], l, r, b) : '0;
                applyStimulus(v, m, lay[t], cnt[t], l, r, b);
                clr = clrIn[t];
            end else begin
                okIn[t] = 1'b0;
                clrIn[t] = 1'b0;
                in_valid = 1'b0;
                clr = 1'b0;
            end
            tick();
            if (t >= 1) begin
                expValid = okIn[t-1] && !clrIn[t-1] && !clrIn[t];
                checks++;
                if (out_valid !== expValid) begin
                    errors++;
                    $display("[TB] FAIL rand_valid slot %0d: got %b, expected %b", t - 1, out_valid, expValid);
                end
                if (expValid) begin
                    checks++;
                    if (a_out !== expVec[t-1] || cnt_out !== 5'(cnt[t-1]) || layer_out !== 5'(lay[t-1] - 1)) begin
                        errors++;
                        $display("[TB] FAIL rand_data slot %0d: got cnt %0d layer %0d data %h, expected %0d %0d %h",
                                 t - 1, cnt_out, layer_out, a_out, cnt[t-1], lay[t-1] - 1, expVec[t-1]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 1, 0, '0, '0, '0);
        test_reset();
        test_f_saturation();
        test_g_saturation();
        test_split();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_invalid_layer();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
